// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg
// Description : Universal shift register: SIPO deserialiser or PISO serialiser
//               with selectable serial bit order.
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int c_CNT_W  = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode,
   input  logic               sin,
   input  logic               shift_en,
   input  logic               load,
   input  logic [WIDTH-1:0]   pdata_in,
   output logic               sout,
   output logic               busy,
   output logic [WIDTH-1:0]   pdata_out,
   output logic               pvalid,
   output logic [c_CNT_W-1:0] bit_cnt
);

   localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(WIDTH);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_sreg;
   logic [WIDTH-1:0]   w_sreg_nxt;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic [WIDTH-1:0]   r_pdata;
   logic [WIDTH-1:0]   w_pdata_nxt;
   logic               r_pvalid;
   logic               w_pvalid_nxt;
   logic               r_mode_prev;
   logic               w_mode_chg;
   logic [WIDTH-1:0]   w_sipo_shift;
   logic [WIDTH-1:0]   w_piso_shift;
   logic               w_out_bit;

   // Bit order only changes which end of the register faces the wire.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign w_sipo_shift = {r_sreg[WIDTH-2:0], sin};
         assign w_piso_shift = {r_sreg[WIDTH-2:0], 1'b0};
         assign w_out_bit    = r_sreg[WIDTH-1];
      end else begin : g_lsb_first
         assign w_sipo_shift = {sin, r_sreg[WIDTH-1:1]};
         assign w_piso_shift = {1'b0, r_sreg[WIDTH-1:1]};
         assign w_out_bit    = r_sreg[0];
      end
   endgenerate

   assign w_mode_chg = (mode != r_mode_prev);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_sreg_nxt   = r_sreg;
      w_cnt_nxt    = r_cnt;
      w_pdata_nxt  = r_pdata;
      w_pvalid_nxt = 1'b0;
      if (w_mode_chg) begin
         // A mode switch abandons any word in progress; pdata_out survives.
         w_state_nxt = ST_IDLE;
         w_sreg_nxt  = '0;
         w_cnt_nxt   = '0;
      end else if (!mode) begin
         w_state_nxt = ST_IDLE;
         if (shift_en) begin
            w_sreg_nxt = w_sipo_shift;
            if (r_cnt == c_CNT_LAST) begin
               w_cnt_nxt    = '0;
               w_pdata_nxt  = w_sipo_shift;
               w_pvalid_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (load) begin
                  w_sreg_nxt  = pdata_in;
                  w_cnt_nxt   = c_CNT_FULL;
                  w_state_nxt = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (shift_en) begin
                  w_sreg_nxt = w_piso_shift;
                  w_cnt_nxt  = r_cnt - c_CNT_ONE;
                  if (r_cnt == c_CNT_ONE) begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sreg      <= '0;
         r_cnt       <= '0;
         r_pdata     <= '0;
         r_pvalid    <= 1'b0;
         r_mode_prev <= mode;
      end else begin
         r_sreg      <= w_sreg_nxt;
         r_cnt       <= w_cnt_nxt;
         r_pdata     <= w_pdata_nxt;
         r_pvalid    <= w_pvalid_nxt;
         r_mode_prev <= mode;
      end
   end

   assign busy      = (r_state == ST_SHIFT);
   assign sout      = (r_state == ST_SHIFT) ? w_out_bit : 1'b0;
   assign pdata_out = r_pdata;
   assign pvalid    = r_pvalid;
   assign bit_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1, serial bit order: 1 = MSB first on the wire, 0 = LSB first.
REQ-003 Port clk  input  1  rising-edge clock; the only clock.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port mode  input  1  0 = SIPO (serial in, parallel out), 1 = PISO (parallel in, serial out).
REQ-006 Port sin  input  1  serial data in (SIPO).
REQ-007 Port shift_en  input  1  advance one bit this cycle (both modes).
REQ-008 Port load  input  1  parallel load request (PISO).
REQ-009 Port pdata_in  input  WIDTH  parallel word to serialise.
REQ-010 Port sout  output  1  serial data out (PISO).
REQ-011 Port busy  output  1  PISO word in flight.
REQ-012 Port pdata_out  output  WIDTH  last completed deserialised word.
REQ-013 Port pvalid  output  1  one-cycle pulse: pdata_out updated.
REQ-014 Port bit_cnt  output  clog2(WIDTH+1)  bits shifted in the current word.

Function
REQ-015 SIPO, MSB_FIRST=1: on shift_en, sreg <= {sreg[WIDTH-2:0], sin}; first received bit ends at bit WIDTH-1.
REQ-016 SIPO, MSB_FIRST=0: on shift_en, sreg <= {sin, sreg[WIDTH-1:1]}; first received bit ends at bit 0.
REQ-017 SIPO: bit_cnt increments on each shift_en; on the WIDTH-th shift, bit_cnt wraps to 0.
REQ-018 On that same edge, pdata_out takes the completed word (including the bit just shifted in) and pvalid is 1 for exactly the following cycle.
REQ-019 pdata_out holds its value between words; back-to-back words with shift_en held high produce a pvalid every WIDTH cycles with no dead cycle.
REQ-020 SIPO ignores load and pdata_in; busy = 0 and sout = 0 in SIPO.
REQ-021 PISO states are IDLE and SHIFT.
REQ-022 IDLE: load=1 captures pdata_in into sreg, sets bit_cnt=WIDTH, busy=1, moves to SHIFT; shift_en is ignored.
REQ-023 In SHIFT, sout = sreg[WIDTH-1] if MSB_FIRST=1, else sreg[0]; the first bit is valid the cycle after load.
REQ-024 In SHIFT, shift_en shifts sreg one place toward the output end (zero fill) and decrements bit_cnt.
REQ-025 The edge that takes bit_cnt from 1 to 0 returns the block to IDLE with busy=0.
REQ-026 Latency: WIDTH shift_en cycles from load to busy low; shift_en low stalls with sout stable.
REQ-027 load while busy=1 is ignored; there is no queueing and the word in flight is unaffected.
REQ-028 load and shift_en together in IDLE: load wins and no bit is consumed.
REQ-029 In IDLE, sout = 0.
REQ-030 Any change of mode between consecutive cycles clears sreg, bit_cnt and busy, and returns to IDLE. No pvalid is produced; pdata_out is retained.
REQ-031 pvalid is never asserted in PISO.

Reset
REQ-032 rst_n=0 at a clock edge sets sreg=0, pdata_out=0, pvalid=0, busy=0, bit_cnt=0, sout=0 and state IDLE.
REQ-033 Reset overrides load, shift_en and mode change in the same cycle.
REQ-034 Reset mid-word discards partial SIPO bits and aborts a PISO word with no pvalid pulse.
REQ-035 Outputs are defined (not X) from the first edge with rst_n=0.

Verification (WIDTH=8)
REQ-036 SIPO, MSB_FIRST=1: shift in 1,0,1,1,0,0,1,0 -> pdata_out=8'hB2, pvalid for one cycle, bit_cnt=0.
REQ-037 SIPO, MSB_FIRST=0: same bit sequence -> pdata_out=8'h4D.
REQ-038 PISO: load 8'hA5, shift_en held high -> sout 1,0,1,0,0,1,0,1; busy high for 8 cycles. A second load of 8'h3C on cycle 3 is ignored.
REQ-039 SIPO stall: 4 bits, shift_en low for 5 cycles, 4 bits -> single correct word; bit_cnt holds at 4 during the stall.
REQ-040 rst_n low after 5 SIPO bits, then 8 fresh bits -> no pvalid for the partial word; the next word is correct.
REQ-041 PISO word 3 bits in flight, mode flipped to 0 -> busy=0, bit_cnt=0 next cycle; pdata_out unchanged.
